// File: rtl/relogio_pkg.sv
// Shared types and constants for the adjustable clock: field selector
// encoding, per-field maxima and small display helpers.
package relogio_pkg;

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2
    } field_e;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    function automatic field_e next_field(input field_e f);
        field_e n;
        case (f)
            FIELD_HOUR: n = FIELD_MIN;
            FIELD_MIN:  n = FIELD_SEC;
            default:    n = FIELD_HOUR;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] field_onehot(input field_e f);
        logic [2:0] oh;
        case (f)
            FIELD_HOUR: oh = 3'b100;
            FIELD_MIN:  oh = 3'b010;
            FIELD_SEC:  oh = 3'b001;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Hour as shown on the display; 12 h mode maps 0 -> 12 and 13..23 -> 1..11.
    function automatic logic [5:0] hour_display(input logic [4:0] hour, input logic mode_12h);
        logic [5:0] h;
        h = {1'b0, hour};
        if (mode_12h) begin
            if (hour == 5'd0) begin
                h = 6'd12;
            end else if (hour > 5'd12) begin
                h = {1'b0, hour} - 6'd12;
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational binary-to-BCD conversion for values 0..59 (one display field).
module bin2bcd_60 (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [5:0] rem;

    always_comb begin
        tens_o = 4'd0;
        rem    = bin_i;
        if (bin_i >= 6'd50) begin
            tens_o = 4'd5;
            rem    = bin_i - 6'd50;
        end else if (bin_i >= 6'd40) begin
            tens_o = 4'd4;
            rem    = bin_i - 6'd40;
        end else if (bin_i >= 6'd30) begin
            tens_o = 4'd3;
            rem    = bin_i - 6'd30;
        end else if (bin_i >= 6'd20) begin
            tens_o = 4'd2;
            rem    = bin_i - 6'd20;
        end else if (bin_i >= 6'd10) begin
            tens_o = 4'd1;
            rem    = bin_i - 6'd10;
        end
        units_o = rem[3:0];
    end

endmodule

// File: rtl/relogio_ajustavel.sv
// Adjustable HH:MM:SS clock with prescaled seconds tick, field adjust via
// switches and blinking of the field being adjusted.
//
// state      | meaning
// FIELD_HOUR | adjust writes sw into hour (also forced on adjust entry)
// FIELD_MIN  | adjust writes sw into minutes
// FIELD_SEC  | adjust writes sw into seconds
module relogio_ajustavel
    import relogio_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HALF = 12_500_000,
    parameter int MODE_12H   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adjust,
    input  logic       set,
    input  logic [5:0] sw,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       pm,
    output logic [2:0] blank,
    output logic       tick
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam bit IS_12H = (MODE_12H != 0);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    field_e        sel_q;
    logic          set_prev_q;
    logic          adj_prev_q;

    logic [3:0]    hour_tens_q, hour_units_q;
    logic [3:0]    min_tens_q, min_units_q;
    logic [3:0]    sec_tens_q, sec_units_q;
    logic          pm_q;

    logic          entering;
    logic          set_rise;
    logic          tick_w;
    field_e        sel_eff;

    assign entering = adjust & ~adj_prev_q;
    assign set_rise = set & ~set_prev_q;
    assign tick_w   = ~adjust & (presc_q == PRESC_LAST);
    // Entry cycle already acts on HOUR so the first sw value lands in the right field.
    assign sel_eff  = entering ? FIELD_HOUR : sel_q;

    // Field selector FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q      <= FIELD_HOUR;
            set_prev_q <= 1'b0;
            adj_prev_q <= 1'b0;
        end else begin
            set_prev_q <= set;
            adj_prev_q <= adjust;
            if (entering) begin
                sel_q <= FIELD_HOUR;
            end else if (adjust && set_rise) begin
                sel_q <= next_field(sel_q);
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (adjust) begin
            presc_d = '0;
            case (sel_eff)
                FIELD_HOUR: if (sw <= HOUR_MAX) hour_d = sw[4:0];
                FIELD_MIN:  if (sw <= MIN_MAX)  min_d  = sw;
                FIELD_SEC:  if (sw <= SEC_MAX)  sec_d  = sw;
                default:    ;
            endcase
        end else if (tick_w) begin
            presc_d = '0;
            if (sec_q == SEC_MAX) begin
                sec_d = 6'd0;
                if (min_q == MIN_MAX) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == HOUR_MAX[4:0]) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (adjust) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q     <= '0;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    logic [5:0] hour_disp;
    logic [3:0] hour_tens_w, hour_units_w;
    logic [3:0] min_tens_w, min_units_w;
    logic [3:0] sec_tens_w, sec_units_w;

    assign hour_disp = hour_display(hour_q, IS_12H);

    bin2bcd_60 u_bcd_hour (
        .bin_i   (hour_disp),
        .tens_o  (hour_tens_w),
        .units_o (hour_units_w)
    );

    bin2bcd_60 u_bcd_min (
        .bin_i   (min_q),
        .tens_o  (min_tens_w),
        .units_o (min_units_w)
    );

    bin2bcd_60 u_bcd_sec (
        .bin_i   (sec_q),
        .tens_o  (sec_tens_w),
        .units_o (sec_units_w)
    );

    // Display registers lag the internal time by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hour_tens_q  <= 4'd0;
            hour_units_q <= 4'd0;
            min_tens_q   <= 4'd0;
            min_units_q  <= 4'd0;
            sec_tens_q   <= 4'd0;
            sec_units_q  <= 4'd0;
            pm_q         <= 1'b0;
        end else begin
            hour_tens_q  <= hour_tens_w;
            hour_units_q <= hour_units_w;
            min_tens_q   <= min_tens_w;
            min_units_q  <= min_units_w;
            sec_tens_q   <= sec_tens_w;
            sec_units_q  <= sec_units_w;
            pm_q         <= IS_12H && (hour_q >= 5'd12);
        end
    end

    assign hour_tens  = hour_tens_q;
    assign hour_units = hour_units_q;
    assign min_tens   = min_tens_q;
    assign min_units  = min_units_q;
    assign sec_tens   = sec_tens_q;
    assign sec_units  = sec_units_q;
    assign pm         = pm_q;
    assign tick       = reset & tick_w;
    assign blank      = (reset && adjust && blink_q) ? field_onehot(sel_eff) : 3'b000;

endmodule

// File: tb/tb_relogio_ajustavel.sv
// Directed bench: a 24 h and a 12 h instance share stimulus; expected
// values are hand-computed for CLK_HZ=4, BLINK_HALF=2.
module tb_relogio_ajustavel;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       adjust = 1'b0;
    logic       set = 1'b0;
    logic [5:0] sw = 6'd0;

    logic [3:0] a_ht, a_hu, a_mt, a_mu, a_st, a_su;
    logic       a_pm, a_tick;
    logic [2:0] a_blank;
    logic [3:0] b_ht, b_hu, b_mt, b_mu, b_st, b_su;
    logic       b_pm, b_tick;
    logic [2:0] b_blank;

    relogio_ajustavel #(.CLK_HZ(4), .BLINK_HALF(2), .MODE_12H(0)) dut24 (
        .clk(clk), .reset(reset), .adjust(adjust), .set(set), .sw(sw),
        .hour_tens(a_ht), .hour_units(a_hu), .min_tens(a_mt), .min_units(a_mu),
        .sec_tens(a_st), .sec_units(a_su), .pm(a_pm), .blank(a_blank), .tick(a_tick)
    );

    relogio_ajustavel #(.CLK_HZ(4), .BLINK_HALF(2), .MODE_12H(1)) dut12 (
        .clk(clk), .reset(reset), .adjust(adjust), .set(set), .sw(sw),
        .hour_tens(b_ht), .hour_units(b_hu), .min_tens(b_mt), .min_units(b_mu),
        .sec_tens(b_st), .sec_units(b_su), .pm(b_pm), .blank(b_blank), .tick(b_tick)
    );

    always #5 clk = ~clk;

    logic [23:0] t24;
    logic [7:0]  hour12;
    assign t24    = {a_ht, a_hu, a_mt, a_mu, a_st, a_su};
    assign hour12 = {b_ht, b_hu};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        adv(2); smp;
        check("rst_time", 32'(t24), 32'h000000);
        check("rst_hour12", 32'(hour12), 32'h00);
        check("rst_pm", 32'(b_pm), 32'd0);
        check("rst_blank", 32'(a_blank), 32'd0);
        check("rst_tick", 32'(a_tick), 32'd0);

        reset = 1'b1;
        adv(1); smp;
        check("h12_after_rst", 32'(hour12), 32'h12);
        check("no_tick_early", 32'(a_tick), 32'd0);
        adv(2); smp;
        check("tick_pulse", 32'(a_tick), 32'd1);
        adv(1); smp;
        check("tick_once", 32'(a_tick), 32'd0);
        check("digit_latency", 32'(t24), 32'h000000);
        adv(1); smp;
        check("first_sec", 32'(t24), 32'h000001);

        adjust = 1'b1; sw = 6'd24;
        adv(1); smp;
        check("no_tick_adjust", 32'(a_tick), 32'd0);
        adv(1); smp;
        check("hour_hold_24", 32'(t24), 32'h000001);
        sw = 6'd17;
        adv(2); smp;
        check("hour_17", 32'(t24), 32'h170001);
        check("hour12_05", 32'(hour12), 32'h05);
        check("pm12_17", 32'(b_pm), 32'd1);
        check("pm24_17", 32'(a_pm), 32'd0);

        sw = 6'd23; adv(1);
        set = 1'b1; adv(1);
        set = 1'b0; sw = 6'd59; adv(1);
        set = 1'b1; adv(1);
        set = 1'b0; adv(1);
        adjust = 1'b0;
        adv(1); smp;
        check("loaded_235959", 32'(t24), 32'h235959);
        check("hour12_11", 32'(hour12), 32'h11);
        check("pm12_23", 32'(b_pm), 32'd1);
        check("blank_off_run", 32'(a_blank), 32'd0);
        adv(2); smp;
        check("tick_after_adjust", 32'(a_tick), 32'd1);
        adv(2); smp;
        check("rollover", 32'(t24), 32'h000000);
        check("pm12_rollover", 32'(b_pm), 32'd0);
        check("hour12_rollover", 32'(hour12), 32'h12);

        adjust = 1'b1; set = 1'b1; sw = 6'd7;
        adv(2); smp;
        check("entry_sel_hour", 32'(t24), 32'h070000);
        check("blink_e2", 32'(a_blank), 32'b100);
        adv(1); smp; check("blink_e3", 32'(a_blank), 32'b100);
        adv(1); smp; check("blink_e4", 32'(a_blank), 32'b000);
        adv(1); smp; check("blink_e5", 32'(a_blank), 32'b000);
        adv(1); smp; check("blink_e6", 32'(a_blank), 32'b100);

        set = 1'b0; adv(1);
        set = 1'b1; adv(1);
        set = 1'b0; sw = 6'd33; adv(1); smp;
        adv(1); smp;
        check("sel_min_load", 32'(t24), 32'h073300);
        check("blank_min", 32'(a_blank), 32'b010);

        set = 1'b1; adv(1);
        set = 1'b0; sw = 6'd44; adv(1);
        adv(1); smp;
        check("sel_sec_load", 32'(t24), 32'h073344);
        adv(1); smp;
        check("blank_sec", 32'(a_blank), 32'b001);

        set = 1'b1; adv(1);
        set = 1'b0; sw = 6'd5; adv(1);
        adv(1); smp;
        check("sel_wrap_hour", 32'(t24), 32'h053344);
        adv(1); smp;
        check("blank_hour_again", 32'(a_blank), 32'b100);

        set = 1'b1; adv(1);
        set = 1'b0; sw = 6'd60; adv(1);
        adv(1); smp;
        check("min_hold_60", 32'(t24), 32'h053344);

        reset = 1'b0;
        adv(1); smp;
        check("rst_mid_time", 32'(t24), 32'h000000);
        check("rst_mid_blank", 32'(a_blank), 32'd0);
        check("rst_mid_tick", 32'(a_tick), 32'd0);
        reset = 1'b1; sw = 6'd9;
        adv(2); smp;
        check("post_rst_sel_hour", 32'(t24), 32'h090000);
        check("post_rst_blank", 32'(a_blank), 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/relogio_ajustavel.md
RELOGIO_AJUSTAVEL -- requirements
Module: relogio_ajustavel

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clk cycles per second tick; SHALL be >= 2.
REQ-002 Parameter BLINK_HALF, default 12_500_000: clk cycles per blink half-period; SHALL be >= 1.
REQ-003 Parameter MODE_12H, default 0: 0 = 24 h display, 1 = 12 h display with pm flag.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  in  1  reset, synchronous, active-low (0 = reset).
REQ-006 adjust  in  1  1 = adjust mode; time does not advance.
REQ-007 set  in  1  rising edge cycles the adjusted field; synchronous to clk, already debounced.
REQ-008 sw  in  6  binary value loaded into the selected field.
REQ-009 hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units  out  4 each  BCD display digits.
REQ-010 pm  out  1  1 when hour >= 12 and MODE_12H=1; 0 otherwise.
REQ-011 blank  out  3  one-hot {hour,min,sec} digit blanking for the blinking field.
REQ-012 tick  out  1  one-cycle pulse on each seconds advance.

Function
REQ-013 Time SHALL be held internally in binary: hour 0..23, min 0..59, sec 0..59.
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 while adjust=0; tick=1 in the cycle it equals CLK_HZ-1, then it wraps to 0.
REQ-015 While adjust=1 the prescaler SHALL be held at 0 and tick SHALL stay 0.
REQ-016 On tick: sec+1; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
REQ-017 Field selector states: HOUR, MIN, SEC; set rising edge (set=1, previous set=0) while adjust=1 advances HOUR->MIN->SEC->HOUR.
REQ-018 Selector SHALL be forced to HOUR in the first cycle adjust=1 after adjust=0; a coincident set edge in that cycle SHALL be ignored.
REQ-019 Set edges while adjust=0 SHALL be ignored.
REQ-020 While adjust=1 the selected field SHALL load sw every cycle if sw <= field max (23 hour, 59 min/sec); otherwise the field SHALL hold.
REQ-021 Hour is always loaded as a 24 h value regardless of MODE_12H.
REQ-022 Digits SHALL be registered, updating 1 cycle after the internal time changes.
REQ-023 MODE_12H=0: hour digits = BCD(hour). MODE_12H=1: hour 0 -> 12, 1..12 -> unchanged, 13..23 -> hour-12; pm = (hour>=12).
REQ-024 Blink counter SHALL count 0..BLINK_HALF-1 while adjust=1 and toggle blink_state at wrap; counter and blink_state SHALL clear to 0 while adjust=0.
REQ-025 blank = one-hot of selected field when adjust=1 and blink_state=1; 3'b000 otherwise.
REQ-026 Leaving adjust SHALL resume counting from the loaded time; the first tick comes CLK_HZ cycles later.

Reset
REQ-027 With reset=0 at a clk edge: time 00:00:00, prescaler 0, selector HOUR, previous set 0, blink counter 0, blink_state 0.
REQ-028 Outputs during reset: all digits 0, pm 0, blank 000, tick 0; in MODE_12H=1 the hour digits SHALL show 1,2 on the first cycle after reset release.
REQ-029 Reset SHALL override adjust, set and tick in the same cycle, including mid-adjust.

Structure
REQ-030 Package relogio_pkg SHALL hold the field enum (FIELD_HOUR, FIELD_MIN, FIELD_SEC) and constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
REQ-031 Sub-module bin2bcd_60 (combinational, 6-bit binary 0..59 -> two BCD digits) SHALL be instantiated per field.

Verification (CLK_HZ=4, BLINK_HALF=2)
REQ-032 Reset release, adjust=0, 4 cycles -> tick pulses once; digits read 00:00:01 one cycle later.
REQ-033 Load 23:59:59 via adjust, then adjust=0 for 4 cycles -> 00:00:00, pm=0.
REQ-034 adjust=1, sw=24 with HOUR selected -> hour holds; sw=17 -> hour 17; MODE_12H=1 shows 05, pm=1.
REQ-035 adjust=1 plus 3 set edges -> selector HOUR->MIN->SEC->HOUR; blank toggles 100/000 every 2 cycles while HOUR is selected.
REQ-036 reset=0 asserted mid-adjust with MIN selected -> next cycle time 00:00:00, selector HOUR, blank 000.
REQ-037 adjust rising together with a set edge -> selector HOUR, not MIN.
